// File: rtl/noc_stage_pkg.sv
// Shared definitions for the elastic NoC pipe: stage states and even parity.
package noc_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Callers zero-extend their vector to this width; zero bits do not change parity.
    localparam int PAR_MAX_W = 1024;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: main + skid register, registered ready so the
// downstream ready never reaches the upstream ready combinationally.
module skid_stage
    import noc_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SIDE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    output logic              out_valid,
    input  logic              out_ready
);

    stage_state_e state, state_nxt;
    logic              push, pop;
    logic              load_main_in, load_main_skid, load_skid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [SIDE_W-1:0] main_side, skid_side;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign load_main_in   = push && ((state == EMPTY) || ((state == BUSY) && pop));
    assign load_main_skid = pop && (state == FULL);
    assign load_skid      = push && !pop && (state == BUSY);

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (push) state_nxt = BUSY;
            BUSY: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = BUSY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
        end
    end

    // Payload registers hold no reset; out_data is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (load_main_in)        main_data <= in_data;
        else if (load_main_skid) main_data <= skid_data;
        if (load_skid)           skid_data <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_side <= '0;
            skid_side <= '0;
        end else begin
            if (load_main_in)        main_side <= in_side;
            else if (load_main_skid) main_side <= skid_side;
            if (load_skid)           skid_side <= in_side;
        end
    end

    assign out_data = main_data;
    assign out_side = main_side;

endmodule

// File: rtl/register_pipe.sv
// Cascade of DEPTH elastic skid stages with an occupancy counter.
// Optional macro REGISTER_PIPE_PARITY_EN carries a parity bit and flags errors.
module register_pipe
    import noc_stage_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int FLAGS      = 3,
    parameter int DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FLIT_WIDTH-1:0]          in_flit,
    input  logic [FLAGS-1:0]               in_flags,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [FLIT_WIDTH-1:0]          out_flit,
    output logic [FLAGS-1:0]               out_flags,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
`ifdef REGISTER_PIPE_PARITY_EN
    ,
    input  logic                           in_par,
    output logic                           out_par,
    output logic                           par_err
`endif
);

    localparam int OCC_W = $clog2(2*DEPTH+1);
`ifdef REGISTER_PIPE_PARITY_EN
    localparam int SIDE_W = FLAGS + 1;
`else
    localparam int SIDE_W = FLAGS;
`endif

    logic [DEPTH:0][FLIT_WIDTH-1:0] flit_c;
    logic [DEPTH:0][SIDE_W-1:0]     side_c;
    logic [DEPTH:0]                 vld_c;
    logic [DEPTH:0]                 rdy_c;
    logic                           in_xfer, out_xfer;

    assign flit_c[0]    = in_flit;
    assign vld_c[0]     = in_valid;
    assign in_ready     = rdy_c[0];
    assign rdy_c[DEPTH] = out_ready;
    assign out_flit     = flit_c[DEPTH];
    assign out_valid    = vld_c[DEPTH];

`ifdef REGISTER_PIPE_PARITY_EN
    assign side_c[0]            = {in_par, in_flags};
    assign {out_par, out_flags} = side_c[DEPTH];
`else
    assign side_c[0] = in_flags;
    assign out_flags = side_c[DEPTH];
`endif

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_stage
        skid_stage #(
            .DATA_W (FLIT_WIDTH),
            .SIDE_W (SIDE_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_data   (flit_c[g]),
            .in_side   (side_c[g]),
            .in_valid  (vld_c[g]),
            .in_ready  (rdy_c[g]),
            .out_data  (flit_c[g+1]),
            .out_side  (side_c[g+1]),
            .out_valid (vld_c[g+1]),
            .out_ready (rdy_c[g+1])
        );
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            unique case ({in_xfer, out_xfer})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef REGISTER_PIPE_PARITY_EN
    // Sticky: only reset clears a detected error.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (out_xfer &&
                     (even_parity(PAR_MAX_W'({out_flags, out_flit})) != out_par)) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_register_pipe.sv
// Self-checking bench for register_pipe: queue-based reference model plus
// directed literal checks, random handshakes, and a DEPTH=1 instance.
module tb_register_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_flit = '0;
    logic [2:0]  in_flags = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_flit;
    logic [2:0]  out_flags;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;

    logic [31:0] u1_in_flit = '0;
    logic        u1_in_valid = 1'b0;
    logic        u1_in_ready;
    logic [31:0] u1_out_flit;
    logic [2:0]  u1_out_flags;
    logic        u1_out_valid;
    logic        u1_out_ready = 1'b0;
    logic [1:0]  u1_occupancy;

`ifdef REGISTER_PIPE_PARITY_EN
    logic par_bad = 1'b0;
    logic in_par, out_par, par_err;
    logic u1_in_par, u1_out_par, u1_par_err;
    assign in_par    = par_bad ? ~(^{in_flags, in_flit}) : (^{in_flags, in_flit});
    assign u1_in_par = ^u1_in_flit;
`endif

    register_pipe #(.FLIT_WIDTH(32), .FLAGS(3), .DEPTH(2)) u0 (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_flags(in_flags),
        .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
        .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy)
`ifdef REGISTER_PIPE_PARITY_EN
        , .in_par(in_par), .out_par(out_par), .par_err(par_err)
`endif
    );

    register_pipe #(.FLIT_WIDTH(32), .FLAGS(3), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .in_flit(u1_in_flit), .in_flags(3'd0),
        .in_valid(u1_in_valid), .in_ready(u1_in_ready), .out_flit(u1_out_flit),
        .out_flags(u1_out_flags), .out_valid(u1_out_valid), .out_ready(u1_out_ready),
        .occupancy(u1_occupancy)
`ifdef REGISTER_PIPE_PARITY_EN
        , .in_par(u1_in_par), .out_par(u1_out_par), .par_err(u1_par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    logic [34:0] mq[$];
    int          acc_cyc[$];
    int          out_cyc[$];
    logic [31:0] out_dat[$];
    logic        stall_q = 1'b0;
    logic        rst_q = 1'b0;
    logic [34:0] hold_q = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered queue of accepted flits, emptied by reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
        end else if (chk_en) begin
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                out_dat.push_back(out_flit);
                n_cmp++;
                if (mq.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: got %0h expected no flit", {out_flags, out_flit});
                end else begin
                    logic [34:0] exp;
                    exp = mq.pop_front();
                    if ({out_flags, out_flit} !== exp) begin
                        n_err++;
                        $display("FAIL out_data: got %0h expected %0h", {out_flags, out_flit}, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                mq.push_back({in_flags, in_flit});
                acc_cyc.push_back(cyc);
            end
        end
        stall_q <= !rst && out_valid && !out_ready;
        hold_q  <= {out_flags, out_flit};
        rst_q   <= rst;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", 64'(occupancy), 64'(mq.size()));
            check("occ_max", 64'(occupancy <= 3'd4), 64'd1);
            if (mq.size() >= 4) check("in_ready_full", 64'(in_ready), 64'd0);
            if (mq.size() == 0) check("out_valid_empty", 64'(out_valid), 64'd0);
            if (rst_q) begin
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_out_flags", 64'(out_flags), 64'd0);
            end else if (stall_q) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'({out_flags, out_flit}), 64'(hold_q));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_flit = '0; in_flags = '0;
        u1_in_valid = 1'b0; u1_out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        acc_cyc.delete(); out_cyc.delete(); out_dat.delete();
    endtask

    initial begin
        tick();
        do_reset();
        chk_en = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_occ", 64'(occupancy), 64'd0);

        // Streaming at full rate: latency 2, no gaps, order kept.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_flit = 32'h11 + 32'(i); in_flags = 3'(i);
            check("t1_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("t1_acc_count", 64'(acc_cyc.size()), 64'd8);
        check("t1_out_count", 64'(out_dat.size()), 64'd8);
        if (out_dat.size() == 8 && acc_cyc.size() == 8) begin
            check("t1_latency", 64'(out_cyc[0] - acc_cyc[0]), 64'd2);
            for (int i = 0; i < 8; i++) begin
                check("t1_data", 64'(out_dat[i]), 64'h11 + 64'(i));
                check("t1_no_gap", 64'(out_cyc[i] - out_cyc[0]), 64'(i));
            end
        end

        // Backpressure fill: four accepts, then drain in order.
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_flit = 32'h20 + 32'(acc_cyc.size());
            tick();
        end
        check("t2_accepts", 64'(acc_cyc.size()), 64'd4);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        check("t2_occ", 64'(occupancy), 64'd4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        check("t2_out_count", 64'(out_dat.size()), 64'd4);
        for (int i = 0; i < 4 && i < out_dat.size(); i++)
            check("t2_data", 64'(out_dat[i]), 64'h20 + 64'(i));
        check("t2_ready_after", 64'(in_ready), 64'd1);

        // Mid-stream reset discards held flits.
        do_reset();
        for (int i = 0; i < 10 && acc_cyc.size() < 3; i++) begin
            in_valid = 1'b1; in_flit = 32'h30 + 32'(acc_cyc.size());
            tick();
        end
        in_valid = 1'b0;
        check("t3_occ3", 64'(occupancy), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_out_valid", 64'(out_valid), 64'd0);
        check("t3_occ0", 64'(occupancy), 64'd0);
        tick();
        check("t3_ready", 64'(in_ready), 64'd1);
        out_dat.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        check("t3_no_stale", 64'(out_dat.size()), 64'd0);

        // Random traffic against the model.
        begin
            int acc = 0;
            int ncyc = 0;
            logic will;
            in_valid = 1'b0;
            while (acc < 10000 && ncyc < 40000) begin
                @(negedge clk);
                will = in_valid && in_ready;
                tick();
                ncyc++;
                if (will) acc++;
                if (!in_valid || will) begin
                    in_valid = ($urandom_range(0, 9) < 7);
                    in_flit  = $urandom;
                    in_flags = 3'($urandom_range(0, 7));
                end
                out_ready = 1'($urandom_range(0, 1));
            end
            check("rand_accepted", 64'(acc), 64'd10000);
            in_valid = 1'b0; out_ready = 1'b1;
            repeat (12) tick();
            check("rand_drained", 64'(occupancy), 64'd0);
        end
`ifdef REGISTER_PIPE_PARITY_EN
        check("par_clean", 64'(par_err), 64'd0);
        do_reset();
        out_ready = 1'b1; par_bad = 1'b1;
        in_valid = 1'b1; in_flit = 32'h0000_0001; in_flags = 3'd0;
        tick();
        in_valid = 1'b0; par_bad = 1'b0;
        repeat (4) tick();
        check("par_err_set", 64'(par_err), 64'd1);
        repeat (5) tick();
        check("par_err_sticky", 64'(par_err), 64'd1);
        do_reset();
        check("par_err_clear", 64'(par_err), 64'd0);
`endif

        // DEPTH=1: simultaneous push and pop keeps one flit resident.
        do_reset();
        u1_out_ready = 1'b1; u1_in_valid = 1'b1; u1_in_flit = 32'h100;
        for (int k = 0; k < 100; k++) begin
            tick();
            check("d1_occ", 64'(u1_occupancy), 64'd1);
            check("d1_valid", 64'(u1_out_valid), 64'd1);
            check("d1_ready", 64'(u1_in_ready), 64'd1);
            check("d1_data", 64'(u1_out_flit), 64'h100 + 64'(k));
            u1_in_flit = 32'h100 + 32'(k) + 32'd1;
        end
        u1_in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
